lifo_fifo_nb: RTL and testbench
===============================

LIFO_FIFO_NB -- requirements
Module: lifo_fifo_nb

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, at least 1.
REQ-002 Parameter DEPTH, default 8: number of storage entries, a power of two, at least 2.
REQ-003 Parameter AW, default $clog2(DEPTH): pointer width, derived; the count width is AW+1.
REQ-004 Port `clk`, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 Port `reset`, input, 1 bit: synchronous, active-low reset.
REQ-006 Port `Din`, input, WIDTH bits: data to push.
REQ-007 Port `push_btn`, input, 1 bit: push request, level input (button); acts on its rising edge.
REQ-008 Port `pop_btn`, input, 1 bit: pop request, level input (button); acts on its rising edge.
REQ-009 Port `mode`, input, 1 bit: requested discipline, 0 = LIFO, 1 = FIFO.
REQ-010 Port `clr_err`, input, 1 bit: level input; clears the sticky error flags.
REQ-011 Port `Dout`, output, WIDTH bits: LIFO top entry or FIFO oldest entry.
REQ-012 Port `empty`, output, 1 bit: asserted when count == 0.
REQ-013 Port `full`, output, 1 bit: asserted when count == DEPTH.
REQ-014 Port `count`, output, AW+1 bits: number of valid entries, 0..DEPTH.
REQ-015 Port `mode_q`, output, 1 bit: discipline currently in effect.
REQ-016 Port `ovf`, output, 1 bit: sticky flag, push attempted while full.
REQ-017 Port `unf`, output, 1 bit: sticky flag, pop attempted while empty.

Function
REQ-018 Each button passes through a two-flop chain (s1 <= btn; s2 <= s1), and its pulse = s1 & ~s2, so one press yields exactly one single-cycle pulse regardless of press length.
REQ-019 A button rising before edge k produces a pulse during cycle k..k+1; the operation commits at edge k+1, and outputs reflect it after edge k+1.
REQ-020 Push pulse alone, not full: Din written at wr_ptr, wr_ptr+1 mod DEPTH, count+1.
REQ-021 Pop pulse alone, not empty: count-1; FIFO: rd_ptr+1 mod DEPTH; LIFO: wr_ptr-1 mod DEPTH.
REQ-022 Push while full (no simultaneous pop): no write, no state change, ovf set at the same edge.
REQ-023 Pop while empty (no simultaneous push): no state change, unf set at the same edge.
REQ-024 Simultaneous push and pop, not empty: LIFO replaces the top entry with Din (wr_ptr and count unchanged); FIFO writes Din at wr_ptr and advances both pointers (count unchanged), including when full.
REQ-025 Simultaneous push and pop, empty: treated as push only; unf not set.
REQ-026 Dout is combinational: LIFO mem[wr_ptr-1], FIFO mem[rd_ptr]; it is all-zero when empty.
REQ-027 mode_q loads mode at any edge where count == 0 and no push pulse is present; otherwise mode changes are ignored until the buffer drains.
REQ-028 clr_err = 1 clears ovf and unf at that edge; an error at the same edge wins (flag remains set).
REQ-029 Pointer arithmetic wraps modulo DEPTH; count never leaves 0..DEPTH.

Reset
REQ-030 reset = 0 at a rising edge: count = 0, wr_ptr = rd_ptr = 0, mode_q = 0, ovf = unf = 0, all button flops = 0; storage is not cleared.
REQ-031 Reset overrides any pulse present in the same cycle; a button held through reset release produces no pulse until released and pressed again.
REQ-032 Reset asserted mid-operation discards contents logically: empty = 1 and Dout = 0 after the edge.

Structure
REQ-033 A shared package holds MODE_LIFO = 0 and MODE_FIFO = 1 and the default WIDTH and DEPTH constants.
REQ-034 One sub-module, btn_pulse (two-flop edge detector with synchronous active-low reset), is instantiated once per button.
REQ-035 Storage is a DEPTH x WIDTH register array with no reset.

Verification
REQ-036 LIFO, DEPTH=8: push 0x11, 0x22, 0x33 -> Dout = 0x33, count = 3; one pop -> Dout = 0x22, count = 2.
REQ-037 FIFO: push 0x11, 0x22, 0x33, then pop -> Dout = 0x22; 10 pushes and 10 pops across the wrap boundary -> data order preserved, empty = 1 at the end.
REQ-038 Fill to 8 entries (full = 1), push 0x99 -> ovf = 1, count = 8, contents unchanged; clr_err -> ovf = 0.
REQ-039 Empty, pop -> unf = 1; simultaneous push 0x5A and pop while empty -> count = 1, Dout = 0x5A.
REQ-040 push_btn held high for 20 cycles -> exactly one push (count +1); mode toggled while count = 2 -> mode_q unchanged until drained to 0.
REQ-041 reset = 0 with 5 entries stored and push_btn held -> count = 0, empty = 1, Dout = 0; no push after reset release until the button is re-pressed.

Source files
------------

// File: rtl/lifo_fifo_nb_pkg.sv
// Shared constants for the dual-discipline (LIFO/FIFO) buffer with button inputs.
package lifo_fifo_nb_pkg;
  localparam logic MODE_LIFO = 1'b0;
  localparam logic MODE_FIFO = 1'b1;
  localparam int   DEF_WIDTH = 8;
  localparam int   DEF_DEPTH = 8;
endpackage

// File: rtl/lifo_fifo_nb_if.sv
// Buffer bus: button/data requests in, data and status out.
interface lifo_fifo_nb_if
  import lifo_fifo_nb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = $clog2(DEF_DEPTH)
);
  logic [WIDTH-1:0] Din;
  logic             push_btn;
  logic             pop_btn;
  logic             mode;
  logic             clr_err;
  logic [WIDTH-1:0] Dout;
  logic             empty;
  logic             full;
  logic [AW:0]      count;
  logic             mode_q;
  logic             ovf;
  logic             unf;

  modport master (
    output Din, push_btn, pop_btn, mode, clr_err,
    input  Dout, empty, full, count, mode_q, ovf, unf
  );
  modport slave (
    input  Din, push_btn, pop_btn, mode, clr_err,
    output Dout, empty, full, count, mode_q, ovf, unf
  );
endinterface

// File: rtl/lifo_fifo_nb_btn_pulse.sv
// Two-flop rising-edge detector for a level button input.
// Pulses are held off after reset until the button has been seen released.
module btn_pulse (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);
  logic s1_q, s2_q, armed_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      s1_q    <= btn_i;
      s2_q    <= s1_q;
      armed_q <= armed_q | ~btn_i;
    end
  end

  assign pulse_o = s1_q & ~s2_q & armed_q;
endmodule

// File: rtl/lifo_fifo_nb.sv
// Buffer switchable between LIFO and FIFO, driven by push/pop buttons, with
// sticky overflow/underflow flags. The discipline only changes while empty.
module lifo_fifo_nb
  import lifo_fifo_nb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input logic           clk,
  input logic           reset,
  lifo_fifo_nb_if.slave bus
);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_m1, waddr;
  logic [AW:0]      count_q, count_d;
  logic             cur_mode_q, cur_mode_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             push_p, pop_p, is_empty, is_full, we;

  btn_pulse u_push (.clk(clk), .reset(reset), .btn_i(bus.push_btn), .pulse_o(push_p));
  btn_pulse u_pop  (.clk(clk), .reset(reset), .btn_i(bus.pop_btn),  .pulse_o(pop_p));

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_FULL);
  assign wr_m1    = wr_ptr_q - PTR_ONE;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    cur_mode_d = cur_mode_q;
    ovf_d      = ovf_q & ~bus.clr_err;
    unf_d      = unf_q & ~bus.clr_err;
    we         = 1'b0;
    waddr      = wr_ptr_q;
    // A pop paired with a push on an empty buffer has nothing to remove.
    if (push_p && (!pop_p || is_empty)) begin
      if (is_full) begin
        ovf_d = 1'b1;
      end else begin
        we       = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        count_d  = count_q + CNT_ONE;
      end
    end else if (push_p && pop_p) begin
      we = 1'b1;
      if (cur_mode_q == MODE_LIFO) begin
        waddr = wr_m1;
      end else begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
    end else if (pop_p) begin
      if (is_empty) begin
        unf_d = 1'b1;
      end else begin
        count_d = count_q - CNT_ONE;
        if (cur_mode_q == MODE_FIFO) rd_ptr_d = rd_ptr_q + PTR_ONE;
        else                         wr_ptr_d = wr_m1;
      end
    end
    if (is_empty && !push_p) cur_mode_d = bus.mode;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cur_mode_q <= MODE_LIFO;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cur_mode_q <= cur_mode_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  // Storage has no reset; emptiness is tracked by count alone.
  always_ff @(posedge clk) begin
    if (we && reset) mem_q[waddr] <= bus.Din;
  end

  assign bus.Dout   = is_empty ? '0 :
                      (cur_mode_q == MODE_FIFO) ? mem_q[rd_ptr_q] : mem_q[wr_m1];
  assign bus.empty  = is_empty;
  assign bus.full   = is_full;
  assign bus.count  = count_q;
  assign bus.mode_q = cur_mode_q;
  assign bus.ovf    = ovf_q;
  assign bus.unf    = unf_q;
endmodule

// File: tb/tb_lifo_fifo_nb.sv
// Directed bench for lifo_fifo_nb (WIDTH=8, DEPTH=8).
module tb_lifo_fifo_nb;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  lifo_fifo_nb_if #(.WIDTH(8), .AW(3)) bus ();
  lifo_fifo_nb #(.WIDTH(8), .DEPTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

  // One button press: pulse forms at the first edge, commits at the second.
  task automatic op(input logic pu, input logic po, input logic [7:0] d, input logic clr);
    @(negedge clk);
    bus.push_btn = pu; bus.pop_btn = po; bus.Din = d; bus.clr_err = clr;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    bus.push_btn = 1'b0; bus.pop_btn = 1'b0; bus.clr_err = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (bus.count !== 4'd0)  begin errors++; $display("FAIL rst_count got %0d exp 0", bus.count); end
    checks++; if (bus.empty !== 1'b1)  begin errors++; $display("FAIL rst_empty got %b exp 1", bus.empty); end
    checks++; if (bus.full !== 1'b0)   begin errors++; $display("FAIL rst_full got %b exp 0", bus.full); end
    checks++; if (bus.Dout !== 8'h00)  begin errors++; $display("FAIL rst_dout got %h exp 00", bus.Dout); end
    checks++; if (bus.mode_q !== 1'b0) begin errors++; $display("FAIL rst_mode got %b exp 0", bus.mode_q); end
    checks++; if (bus.ovf !== 1'b0 || bus.unf !== 1'b0) begin errors++; $display("FAIL rst_flags got %b%b exp 00", bus.ovf, bus.unf); end
  endtask

  task automatic test_lifo;
    op(1, 0, 8'h11, 0); op(1, 0, 8'h22, 0); op(1, 0, 8'h33, 0);
    checks++; if (bus.Dout !== 8'h33)  begin errors++; $display("FAIL lifo_top got %h exp 33", bus.Dout); end
    checks++; if (bus.count !== 4'd3)  begin errors++; $display("FAIL lifo_cnt3 got %0d exp 3", bus.count); end
    op(0, 1, 8'h00, 0);
    checks++; if (bus.Dout !== 8'h22)  begin errors++; $display("FAIL lifo_pop got %h exp 22", bus.Dout); end
    checks++; if (bus.count !== 4'd2)  begin errors++; $display("FAIL lifo_cnt2 got %0d exp 2", bus.count); end
    op(1, 1, 8'h44, 0);
    checks++; if (bus.Dout !== 8'h44 || bus.count !== 4'd2) begin errors++; $display("FAIL lifo_replace got %h/%0d exp 44/2", bus.Dout, bus.count); end
    op(0, 1, 8'h00, 0);
    checks++; if (bus.Dout !== 8'h11)  begin errors++; $display("FAIL lifo_under got %h exp 11", bus.Dout); end
    op(0, 1, 8'h00, 0);
    checks++; if (bus.empty !== 1'b1 || bus.Dout !== 8'h00) begin errors++; $display("FAIL lifo_drain got %b/%h exp 1/00", bus.empty, bus.Dout); end
  endtask

  task automatic test_held;
    @(negedge clk);
    bus.Din = 8'h5C; bus.push_btn = 1'b1;
    repeat (20) @(negedge clk);
    bus.push_btn = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.count !== 4'd1 || bus.Dout !== 8'h5C) begin errors++; $display("FAIL held_once got %0d/%h exp 1/5c", bus.count, bus.Dout); end
    op(0, 1, 8'h00, 0);
  endtask

  task automatic test_fifo;
    bus.mode = 1'b1;
    op(1, 0, 8'h11, 0);
    checks++; if (bus.mode_q !== 1'b1) begin errors++; $display("FAIL fifo_mode got %b exp 1", bus.mode_q); end
    op(1, 0, 8'h22, 0); op(1, 0, 8'h33, 0);
    checks++; if (bus.Dout !== 8'h11)  begin errors++; $display("FAIL fifo_head got %h exp 11", bus.Dout); end
    op(0, 1, 8'h00, 0);
    checks++; if (bus.Dout !== 8'h22)  begin errors++; $display("FAIL fifo_pop got %h exp 22", bus.Dout); end
    op(0, 1, 8'h00, 0); op(0, 1, 8'h00, 0);
    // 10 pushes / 10 pops spanning the pointer wrap, three entries in flight
    for (int i = 0; i < 3; i++) op(1, 0, 8'hA0 + 8'(i), 0);
    for (int i = 3; i < 10; i++) begin
      op(1, 0, 8'hA0 + 8'(i), 0);
      checks++; if (bus.Dout !== 8'hA0 + 8'(i - 3)) begin errors++; $display("FAIL fifo_wrap%0d got %h exp %h", i, bus.Dout, 8'hA0 + 8'(i - 3)); end
      op(0, 1, 8'h00, 0);
    end
    for (int i = 7; i < 10; i++) begin
      checks++; if (bus.Dout !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL fifo_tail%0d got %h exp %h", i, bus.Dout, 8'hA0 + 8'(i)); end
      op(0, 1, 8'h00, 0);
    end
    checks++; if (bus.empty !== 1'b1)  begin errors++; $display("FAIL fifo_empty got %b exp 1", bus.empty); end
  endtask

  task automatic test_full;
    for (int i = 0; i < 8; i++) op(1, 0, 8'h60 + 8'(i), 0);
    checks++; if (bus.full !== 1'b1 || bus.count !== 4'd8) begin errors++; $display("FAIL full_set got %b/%0d exp 1/8", bus.full, bus.count); end
    op(1, 0, 8'h99, 0);
    checks++; if (bus.ovf !== 1'b1)    begin errors++; $display("FAIL ovf_set got %b exp 1", bus.ovf); end
    checks++; if (bus.count !== 4'd8 || bus.Dout !== 8'h60) begin errors++; $display("FAIL ovf_hold got %0d/%h exp 8/60", bus.count, bus.Dout); end
    op(0, 0, 8'h00, 1);
    checks++; if (bus.ovf !== 1'b0)    begin errors++; $display("FAIL ovf_clr got %b exp 0", bus.ovf); end
    op(1, 0, 8'h99, 1);
    checks++; if (bus.ovf !== 1'b1)    begin errors++; $display("FAIL ovf_wins got %b exp 1", bus.ovf); end
    op(0, 0, 8'h00, 1);
    op(1, 1, 8'h77, 0);
    checks++; if (bus.count !== 4'd8 || bus.Dout !== 8'h61) begin errors++; $display("FAIL full_pushpop got %0d/%h exp 8/61", bus.count, bus.Dout); end
    for (int i = 1; i < 8; i++) begin
      checks++; if (bus.Dout !== 8'h60 + 8'(i)) begin errors++; $display("FAIL full_drain%0d got %h exp %h", i, bus.Dout, 8'h60 + 8'(i)); end
      op(0, 1, 8'h00, 0);
    end
    checks++; if (bus.Dout !== 8'h77)  begin errors++; $display("FAIL full_last got %h exp 77", bus.Dout); end
    op(0, 1, 8'h00, 0);
    checks++; if (bus.empty !== 1'b1 || bus.ovf !== 1'b0) begin errors++; $display("FAIL full_end got %b/%b exp 1/0", bus.empty, bus.ovf); end
  endtask

  task automatic test_unf;
    op(0, 1, 8'h00, 0);
    checks++; if (bus.unf !== 1'b1 || bus.count !== 4'd0) begin errors++; $display("FAIL unf_set got %b/%0d exp 1/0", bus.unf, bus.count); end
    op(0, 0, 8'h00, 1);
    checks++; if (bus.unf !== 1'b0)    begin errors++; $display("FAIL unf_clr got %b exp 0", bus.unf); end
    op(1, 1, 8'h5A, 0);
    checks++; if (bus.count !== 4'd1 || bus.Dout !== 8'h5A) begin errors++; $display("FAIL empty_pushpop got %0d/%h exp 1/5a", bus.count, bus.Dout); end
    checks++; if (bus.unf !== 1'b0)    begin errors++; $display("FAIL empty_pushpop_unf got %b exp 0", bus.unf); end
    op(0, 1, 8'h00, 0);
  endtask

  task automatic test_mode_hold;
    bus.mode = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.mode_q !== 1'b0) begin errors++; $display("FAIL mode_lifo got %b exp 0", bus.mode_q); end
    op(1, 0, 8'h01, 0); op(1, 0, 8'h02, 0);
    bus.mode = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.mode_q !== 1'b0 || bus.Dout !== 8'h02) begin errors++; $display("FAIL mode_held got %b/%h exp 0/02", bus.mode_q, bus.Dout); end
    op(0, 1, 8'h00, 0);
    checks++; if (bus.mode_q !== 1'b0 || bus.Dout !== 8'h01) begin errors++; $display("FAIL mode_held1 got %b/%h exp 0/01", bus.mode_q, bus.Dout); end
    op(0, 1, 8'h00, 0);
    checks++; if (bus.mode_q !== 1'b1) begin errors++; $display("FAIL mode_drained got %b exp 1", bus.mode_q); end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 5; i++) op(1, 0, 8'h31 + 8'(i), 0);
    checks++; if (bus.count !== 4'd5)  begin errors++; $display("FAIL mid_fill got %0d exp 5", bus.count); end
    @(negedge clk);
    bus.Din = 8'h77; bus.push_btn = 1'b1; reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.Dout !== 8'h00) begin errors++; $display("FAIL mid_reset got %0d/%b/%h exp 0/1/00", bus.count, bus.empty, bus.Dout); end
    reset = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (bus.count !== 4'd0)  begin errors++; $display("FAIL held_thru_reset got %0d exp 0", bus.count); end
    bus.push_btn = 1'b0;
    op(1, 0, 8'h42, 0);
    checks++; if (bus.count !== 4'd1 || bus.Dout !== 8'h42) begin errors++; $display("FAIL repress got %0d/%h exp 1/42", bus.count, bus.Dout); end
  endtask

  initial begin
    reset = 1'b0;
    bus.Din = '0; bus.push_btn = 1'b0; bus.pop_btn = 1'b0; bus.mode = 1'b0; bus.clr_err = 1'b0;
    repeat (3) @(posedge clk);
    test_reset;
    reset = 1'b1;
    test_lifo;
    test_held;
    test_fifo;
    test_full;
    test_unf;
    test_mode_hold;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
